// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths and md result entry type for the writeback arbiter
package wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } md_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order buffer of multi-cycle results awaiting the register-file write port
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push,
  input  md_entry_t                      push_entry,
  input  logic                           pop,
  output logic [$clog2(DEPTH):0]         count,
  output md_entry_t                      head,
  output logic [DEPTH-1:0]               ent_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]   ent_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  md_entry_t        mem [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic             do_push;
  logic             do_pop;

  // Self-protection: never overfill or pop an empty buffer, whatever the caller asks.
  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);

  // Pointer, occupancy and valid-bit bookkeeping; reset discards every buffered result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count     <= '0;
      rptr      <= '0;
      wptr      <= '0;
      ent_valid <= '0;
    end else begin
      if (do_push) begin
        ent_valid[wptr] <= 1'b1;
        wptr            <= wptr + PW'(1);
      end
      if (do_pop) begin
        ent_valid[rptr] <= 1'b0;
        rptr            <= rptr + PW'(1);
      end
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Entry payload storage; contents are meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_entry;
    end
  end

  assign head = mem[rptr];

  // Expose every slot's destination register for the decode-stage hazard match.
  always_comb begin
    ent_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i] = mem[i].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - shares the register-file write port between pipeline writeback and buffered md results
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [REG_AW-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd,
  input  logic [REG_AW-1:0] q_a1,
  input  logic [REG_AW-1:0] q_a2,
  output logic              q_hit1,
  output logic              q_hit2
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0]                count;
  md_entry_t                    head;
  md_entry_t                    push_entry;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][REG_AW-1:0] ent_rd;
  logic                         pipe_write;
  logic                         fifo_empty;
  logic                         push;
  logic                         pop;

  // Writes to x0 are architectural no-ops, so they neither win the port nor occupy a slot.
  assign pipe_write = wb_we && (wb_rd != '0);
  assign fifo_empty = (count == '0);
  assign md_ready   = reset_n && (count < FULL_CNT);
  assign push       = md_valid && md_ready && (md_rd != '0);
  assign pop        = !pipe_write && !fifo_empty;
  assign push_entry = '{rd: md_rd, data: md_data};

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head),
    .ent_valid  (ent_valid),
    .ent_rd     (ent_rd)
  );

  // Write-port mux: pipeline has priority, otherwise drain the buffer head.
  always_comb begin
    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    if (pipe_write) begin
      rf_we = 1'b1;
      rf_a3 = wb_rd;
      rf_wd = wb_data;
    end else if (!fifo_empty) begin
      rf_we = 1'b1;
      rf_a3 = head.rd;
      rf_wd = head.data;
    end
  end

  // Hazard match of decode sources against every buffered, not yet retired md result.
  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (q_a1 != '0) && (ent_rd[i] == q_a1)) q_hit1 = 1'b1;
      if (ent_valid[i] && (q_a2 != '0) && (ent_rd[i] == q_a2)) q_hit2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic              clk;
  logic              reset_n;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              md_valid;
  logic              md_ready;
  logic [REG_AW-1:0] md_rd;
  logic [DATA_W-1:0] md_data;
  logic              rf_we;
  logic [REG_AW-1:0] rf_a3;
  logic [DATA_W-1:0] rf_wd;
  logic [REG_AW-1:0] q_a1;
  logic [REG_AW-1:0] q_a2;
  logic              q_hit1;
  logic              q_hit2;

  typedef struct {
    logic              we;
    logic [REG_AW-1:0] a3;
    logic [DATA_W-1:0] wd;
    logic              ready;
    logic              hit1;
    logic              hit2;
  } exp_t;

  exp_t      expq[$];
  md_entry_t model[$];
  exp_t      e;
  int        n_checks = 0;
  int        n_fails  = 0;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_rd    (md_rd),
    .md_data  (md_data),
    .rf_we    (rf_we),
    .rf_a3    (rf_a3),
    .rf_wd    (rf_wd),
    .q_a1     (q_a1),
    .q_a2     (q_a2),
    .q_hit1   (q_hit1),
    .q_hit2   (q_hit2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic model_hit(input logic [REG_AW-1:0] a);
    if (a == '0) return 1'b0;
    foreach (model[i]) if (model[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, record the expected response, then advance the model past the edge.
  task automatic step(input logic rst_n, input logic we, input logic [4:0] rd,
                      input logic [31:0] d, input logic mv, input logic [4:0] mrd,
                      input logic [31:0] md, input logic [4:0] a1, input logic [4:0] a2);
    exp_t x;
    logic from_fifo;
    md_entry_t ne;
    @(negedge clk);
    reset_n = rst_n; wb_we = we; wb_rd = rd; wb_data = d;
    md_valid = mv; md_rd = mrd; md_data = md; q_a1 = a1; q_a2 = a2;
    from_fifo = 1'b0;
    if (we && rd != 0) begin
      x.we = 1'b1; x.a3 = rd; x.wd = d;
    end else if (model.size() > 0) begin
      x.we = 1'b1; x.a3 = model[0].rd; x.wd = model[0].data; from_fifo = 1'b1;
    end else begin
      x.we = 1'b0; x.a3 = '0; x.wd = '0;
    end
    x.ready = rst_n && (model.size() < DEPTH);
    x.hit1  = model_hit(a1);
    x.hit2  = model_hit(a2);
    expq.push_back(x);
    if (!rst_n) begin
      model.delete();
    end else begin
      if (from_fifo) void'(model.pop_front());
      if (mv && x.ready && mrd != 0) begin
        ne.rd = mrd; ne.data = md;
        model.push_back(ne);
      end
    end
  endtask

  task automatic idle(input logic [4:0] a1);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a1, 5'd0);
  endtask

  // Monitor: each cycle, well clear of the rising edge, compare outputs with the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("rf_we",    32'(rf_we),    32'(e.we));
      check("rf_a3",    32'(rf_a3),    32'(e.a3));
      check("rf_wd",    rf_wd,         e.wd);
      check("md_ready", 32'(md_ready), 32'(e.ready));
      check("q_hit1",   32'(q_hit1),   32'(e.hit1));
      check("q_hit2",   32'(q_hit2),   32'(e.hit2));
    end
  end

  initial begin
    reset_n = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0; q_a1 = '0; q_a2 = '0;

    // Reset, then the first idle cycle after release.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(5'd3);

    // Pipeline only.
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);

    // md only, hit visible only while buffered.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0);
    idle(5'd7);
    idle(5'd7);

    // Contention: two buffered behind four pipeline writes.
    step(1'b1, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd4);
    step(1'b1, 1'b1, 5'd11, 32'hA1, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
    step(1'b1, 1'b1, 5'd12, 32'hA2, 1'b1, 5'd8, 32'h88, 5'd3, 5'd4);
    step(1'b1, 1'b1, 5'd13, 32'hA3, 1'b1, 5'd8, 32'h88, 5'd3, 5'd4);
    idle(5'd3);
    idle(5'd4);
    idle(5'd0);

    // Full with pop: not ready while full even though the head drains.
    step(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'h300, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd4, 32'h400, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h900, 5'd9, 5'd3);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h900, 5'd9, 5'd4);
    idle(5'd9);
    idle(5'd9);

    // x0 handling.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD, 5'd0, 5'd0);
    idle(5'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 5'd6, 5'd0);
    step(1'b1, 1'b1, 5'd0, 32'hBAD0, 1'b0, 5'd0, 32'd0, 5'd6, 5'd0);
    idle(5'd6);

    // Reset mid-operation discards buffered results.
    step(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'h3, 5'd3, 5'd4);
    step(1'b1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd4, 32'h4, 5'd3, 5'd4);
    step(1'b0, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
    idle(5'd3);
    idle(5'd4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 4; i++) idle(5'd0);

    @(negedge clk);
    #5;
    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
